mult4u_rr_sched: RTL
====================

# mult4u_rr_sched

Time-multiplexed scheduler that shares one combinational unsigned 4x4 multiplier (8-bit product) among NREQ requesters. It arbitrates round-robin, drives the multiplier operands, and performs a temporal-redundancy check: each job is evaluated twice, once as A*B and once with operands swapped as B*A. Jobs whose two passes disagree are retried, and unresolved mismatches are flagged to the consumer. It sits between the requesting datapaths and the evolved fault-resilient multiplier netlist, adding fault detection at the system level.

## Interface
- NREQ, 4, number of requesters; legal values 2, 4, 8
- MAX_RETRY, 2, re-executions allowed after a mismatch before reporting an error; legal range 0..7
- ID_W, log2(NREQ), derived width of the requester id (not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester job valid
- req_a  in  4*NREQ  operand A; requester i uses bits [4i+3:4i]
- req_b  in  4*NREQ  operand B, packed the same way
- req_ready  out  NREQ  one-hot grant; a job is accepted when req_valid[i] & req_ready[i]
- mul_a  out  4  operand A to the shared multiplier
- mul_b  out  4  operand B to the shared multiplier
- mul_p  in  8  product from the multiplier; combinational, settles within one cycle
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_p  out  8  product
- rsp_err  out  1  1 = the two passes still disagreed after MAX_RETRY retries
- err_cnt  out  8  saturating count of detected pass mismatches

## Operation
- States are IDLE, PASS1, PASS2 and RESP. Only one job is in flight at a time.
- IDLE:
  - req_ready is combinational. It grants the first requester with req_valid set, searching from ptr+1 and wrapping modulo NREQ.
  - On acceptance: latch a_q, b_q and id_q; set ptr to the granted index; clear retry_q; go to PASS1.
  - With no valid requester, req_ready = 0 and the FSM stays in IDLE.
- PASS1: mul_a = a_q, mul_b = b_q. Capture p1_q = mul_p at the clock edge, then go to PASS2.
- PASS2: mul_a = b_q, mul_b = a_q. Compare mul_p against p1_q:
  - Equal: rsp_p = p1_q, rsp_err = 0, go to RESP.
  - Unequal: increment err_cnt (saturating at 255).
    - If retry_q < MAX_RETRY: retry_q++ and go to PASS1.
    - Otherwise: rsp_p = p1_q, rsp_err = 1, go to RESP.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_p and rsp_err are held stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready, go to IDLE; no new grant is issued in that cycle.
- mul_a and mul_b are 0 in IDLE and RESP.
- req_ready is 0 in every state except IDLE.
- Arithmetic: 4b x 4b unsigned, full 8-bit product, no truncation. 15*15 = 225 (0xE1).
- Requester inputs are sampled only in the grant cycle. Deasserting req_valid or changing operands afterwards has no effect on the job in flight.

## Timing
- Reset values: req_ready = 0, mul_a = 0, mul_b = 0, rsp_valid = 0, rsp_id = 0, rsp_p = 0, rsp_err = 0, err_cnt = 0, state = IDLE.
- After reset, ptr = NREQ-1, so requester 0 has first priority.
- If acceptance happens in cycle t, rsp_valid is asserted from cycle t+3 when there is no mismatch. Each retry adds 2 cycles, so the worst case is t+3+2*MAX_RETRY.
- Minimum throughput is one job per 4 cycles: grant, PASS1, PASS2, then RESP with the handshake completing immediately.
- Mismatch accounting: err_cnt increments once per mismatching PASS2, including the final one that raises rsp_err.
- Reset asserted mid-job, in any state, aborts the job immediately and asynchronously. No response is produced and no partial state is retained.
- Several requesters valid in the same cycle: exactly one grant, chosen round-robin. A requester that stays valid is served at the latest within NREQ jobs.

## Test plan
- Single job: requester 2 with a=13, b=11, accepted at cycle t -> rsp_valid at t+3 with rsp_id=2, rsp_p=143, rsp_err=0; err_cnt stays 0.
- Fairness: all 4 requesters held valid with a=i+1, b=15 -> grants in order 0,1,2,3,0; products 15, 30, 45, 60; one response every 4 cycles with rsp_ready tied to 1.
- Backpressure: 15*15 completes while rsp_ready=0 for 5 cycles -> rsp_valid, rsp_p=225 and rsp_id held stable; req_ready stays 0; IDLE is entered one cycle after rsp_ready rises.
- Transient fault: the bench multiplier model flips bit 3 of the product on the first PASS1 only, for 6*7 -> one retry; rsp_p=42, rsp_err=0, err_cnt=1, response at t+5.
- Persistent asymmetric fault: the model flips bit 0 whenever mul_a > mul_b, for 9*4 with MAX_RETRY=2 -> three mismatches, rsp_err=1, rsp_p=37 (faulty p1), err_cnt=3, response at t+7.
- Reset during PASS2 of 5*5 -> all outputs return to their reset values asynchronously. After release, requester 0 is granted first and 0*9 returns rsp_p=0.

Source files
------------

// File: rtl/mult4u_rr_sched.sv
// mult4u_rr_sched
//   Shares one combinational unsigned 4x4 multiplier among NREQ requesters.
//   Each job is computed twice: once as A*B and once with the operands
//   swapped (B*A). If the two products differ, the job is re-run up to
//   MAX_RETRY times. If they still differ, the result is flagged with rsp_err.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid[NREQ]     per-requester job valid
//   req_a/req_b         packed 4-bit operands, lane i at [4i+3:4i]
//   req_ready[NREQ]     one-hot round-robin grant (IDLE only)
//   mul_a/mul_b/mul_p   shared multiplier operands / product
//   rsp_*               result handshake: id, product, error flag
//   err_cnt             saturating count of mismatching second passes
module mult4u_rr_sched #(
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 2,
    localparam int ID_W     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_a,
    input  logic [4*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [3:0]           mul_a,
    output logic [3:0]           mul_b,
    input  logic [7:0]           mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_p,
    output logic                 rsp_err,
    output logic [7:0]           err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PASS1,
        S_PASS2,
        S_RESP
    } state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      id_q;
    logic [3:0]           a_q, b_q;
    logic [7:0]           p1_q;
    logic [2:0]           retry_q;
    logic [7:0]           rsp_p_q;
    logic                 rsp_err_q;
    logic [7:0]           err_cnt_q;

    logic [NREQ-1:0][3:0] a_lanes, b_lanes;
    logic                 gnt_any;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W-1:0]      idx;
    logic                 mismatch;
    logic                 can_retry;

    assign a_lanes = req_a;
    assign b_lanes = req_b;

    // Round-robin search starting one past the last grant. NREQ is a power
    // of two, so the ID_W-bit sum wraps modulo NREQ on its own; k == NREQ
    // lands back on ptr itself, giving it the lowest priority.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && gnt_any)
            req_ready[gnt_idx] = 1'b1;
    end

    // The second pass uses swapped operands, so a fault that depends on
    // operand order is seen as a mismatch.
    always_comb begin
        mul_a = 4'd0;
        mul_b = 4'd0;
        case (state)
            S_PASS1: begin mul_a = a_q; mul_b = b_q; end
            S_PASS2: begin mul_a = b_q; mul_b = a_q; end
            default: ;
        endcase
    end

    assign mismatch  = (state == S_PASS2) && (mul_p != p1_q);
    assign can_retry = retry_q < 3'(MAX_RETRY);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (gnt_any) state_nxt = S_PASS1;
            S_PASS1: state_nxt = S_PASS2;
            S_PASS2: state_nxt = (mismatch && can_retry) ? S_PASS1 : S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= ID_W'(NREQ - 1);
            id_q      <= '0;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            p1_q      <= 8'd0;
            retry_q   <= 3'd0;
            rsp_p_q   <= 8'd0;
            rsp_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        a_q     <= a_lanes[gnt_idx];
                        b_q     <= b_lanes[gnt_idx];
                        id_q    <= gnt_idx;
                        ptr     <= gnt_idx;
                        retry_q <= 3'd0;
                    end
                end
                S_PASS1: p1_q <= mul_p;
                S_PASS2: begin
                    if (mismatch) begin
                        if (err_cnt_q != 8'hFF)
                            err_cnt_q <= err_cnt_q + 8'd1;
                        if (can_retry) begin
                            retry_q <= retry_q + 3'd1;
                        end else begin
                            rsp_p_q   <= p1_q;
                            rsp_err_q <= 1'b1;
                        end
                    end else begin
                        rsp_p_q   <= p1_q;
                        rsp_err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
